if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC and issues single-outstanding word requests to instruction memory.
- Presents the fetched instruction to ID, where the register numbers feeding the load-use hazard detector are decoded.
- Consumes the hazard detector's stall and the EX-stage branch/jump redirect: freezes on stall, discards wrong-path fetches on redirect.

---
 rtl/if_stage_pkg.sv | 24 ++
 rtl/if_stage_if_id_reg.sv | 53 +++++
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_pkg
// Brief    : Shared core types and constants for the RV32I fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    localparam int c_XLEN = 32;

    typedef logic [c_XLEN-1:0] pc_t;
    typedef logic [4:0]        reg_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with load, hold and flush controls.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc4,
    output logic [31:0]     o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;
    logic [31:0]     r_instr;

    // Flush dominates load; the PC fields are left alone on flush.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_pc4   <= RESET_PC + XLEN'(4);
            r_instr <= NOP_INSTR;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_pc4   <= i_pc + XLEN'(4);
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_instr = r_instr;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch FSM, PC and IF/ID register of the RV32I core.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_EX_redirect,
    input  logic [XLEN-1:0] i_EX_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_ID_valid,
    output logic [XLEN-1:0] o_ID_pc,
    output logic [XLEN-1:0] o_ID_pc4,
    output logic [31:0]     o_ID_instr
);

    import if_stage_pkg::*;

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_hold_valid;
    logic            w_hold_valid_nxt;
    logic [31:0]     r_hold_instr;
    logic [31:0]     w_hold_instr_nxt;
    logic [XLEN-1:0] r_hold_pc;
    logic [XLEN-1:0] w_hold_pc_nxt;
    logic            w_id_load;
    logic            w_id_flush;
    logic [XLEN-1:0] w_id_pc;
    logic [31:0]     w_id_instr;
    logic            w_unused_lsbs;

    // Target is always word aligned; the low bits are dropped on purpose.
    assign w_unused_lsbs = ^i_EX_redirect_pc[1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_hold_valid <= 1'b0;
            r_hold_instr <= NOP_INSTR;
            r_hold_pc    <= RESET_PC;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_hold_valid_nxt = r_hold_valid;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc_nxt    = r_hold_pc;
        w_id_load        = 1'b0;
        w_id_flush       = 1'b0;
        w_id_pc          = r_pc;
        w_id_instr       = i_imem_rdata;

        if (i_EX_redirect) begin
            // Any fetch still owed by memory must be drained in DROP.
            w_pc_nxt         = {i_EX_redirect_pc[XLEN-1:2], 2'b00};
            w_id_flush       = 1'b1;
            w_hold_valid_nxt = 1'b0;
            case (r_state)
                FETCH:   w_state_nxt = i_imem_gnt    ? DROP  : FETCH;
                WAIT:    w_state_nxt = i_imem_rvalid ? FETCH : DROP;
                HOLD:    w_state_nxt = FETCH;
                DROP:    w_state_nxt = i_imem_rvalid ? FETCH : DROP;
                default: w_state_nxt = FETCH;
            endcase
        end else begin
            case (r_state)
                FETCH: begin
                    if (i_imem_gnt) begin
                        w_state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (i_imem_rvalid) begin
                        if (!i_stall) begin
                            w_id_load   = 1'b1;
                            w_pc_nxt    = r_pc + XLEN'(4);
                            w_state_nxt = FETCH;
                        end else begin
                            w_hold_valid_nxt = 1'b1;
                            w_hold_instr_nxt = i_imem_rdata;
                            w_hold_pc_nxt    = r_pc;
                            w_state_nxt      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!i_stall) begin
                        w_id_load        = 1'b1;
                        w_id_pc          = r_hold_pc;
                        w_id_instr       = r_hold_instr;
                        w_pc_nxt         = r_pc + XLEN'(4);
                        w_hold_valid_nxt = 1'b0;
                        w_state_nxt      = FETCH;
                    end
                end
                DROP: begin
                    if (i_imem_rvalid) begin
                        w_state_nxt = FETCH;
                    end
                end
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    assign o_imem_req  = (r_state == FETCH) && !i_rst;
    assign o_imem_addr = r_pc;

    if_id_reg #(
        .XLEN      (XLEN),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_id_load),
        .i_flush (w_id_flush),
        .i_pc    (w_id_pc),
        .i_instr (w_id_instr),
        .o_valid (o_ID_valid),
        .o_pc    (o_ID_pc),
        .o_pc4   (o_ID_pc4),
        .o_instr (o_ID_instr)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Randomized self-checking bench for if_stage with a stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] c_RST_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    if_stage #(
        .XLEN      (32),
        .RESET_PC  (c_RST_PC),
        .NOP_INSTR (c_NOP)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall          (stall),
        .i_EX_redirect    (redir),
        .i_EX_redirect_pc (redir_pc),
        .o_imem_req       (req),
        .o_imem_addr      (addr),
        .i_imem_gnt       (gnt),
        .i_imem_rvalid    (rvalid),
        .i_imem_rdata     (rdata),
        .o_ID_valid       (id_valid),
        .o_ID_pc          (id_pc),
        .o_ID_pc4         (id_pc4),
        .o_ID_instr       (id_instr)
    );

    // Program stream model: next PC ID must see, and the one pending memory op.
    logic [31:0] stream_pc;
    int          deliveries;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    bit          s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    bit          p_stall;
    bit          p_redir;
    bit          p_req_wait;
    logic [31:0] p_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'd0, req},      32'd0);
        check({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, "_pc"},    id_pc,             c_RST_PC);
        check({tag, "_pc4"},   id_pc4,            c_RST_PC + 32'd4);
        check({tag, "_instr"}, id_instr,          c_NOP);
    endtask

    task automatic reset_model();
        stream_pc  = c_RST_PC;
        pend       = 1'b0;
        pend_cnt   = 0;
        pend_addr  = '0;
        s_valid    = 1'b0;
        s_pc       = c_RST_PC;
        s_instr    = c_NOP;
        p_stall    = 1'b0;
        p_redir    = 1'b0;
        p_req_wait = 1'b0;
        p_addr     = '0;
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            // Effect of the controls driven on the previous cycle
            if (p_redir) begin
                check("flush_valid", {31'd0, id_valid}, 32'd0);
                check("flush_instr", id_instr, c_NOP);
            end else if (p_stall) begin
                check("stall_valid", {31'd0, id_valid}, {31'd0, s_valid});
                check("stall_pc",    id_pc,    s_pc);
                check("stall_instr", id_instr, s_instr);
            end
            check("id_instr", id_instr, id_valid ? instr_of(id_pc) : c_NOP);
            check("id_pc4",   id_pc4,   id_pc + 32'd4);
            if (id_valid && (!s_valid || id_pc != s_pc)) begin
                check("deliver_pc", id_pc, stream_pc);
                stream_pc = stream_pc + 32'd4;
                deliveries++;
            end
            if (p_req_wait) begin
                check("req_held",  {31'd0, req}, 32'd1);
                check("addr_held", addr, p_addr);
            end
            if (req) begin
                check("req_addr",        addr, stream_pc);
                check("one_outstanding", {31'd0, pend}, 32'd0);
            end

            // Memory response then grant for the coming edge
            rvalid = 1'b0;
            rdata  = $urandom;
            if (pend) begin
                if (pend_cnt == 0) begin
                    rvalid = 1'b1;
                    rdata  = instr_of(pend_addr);
                    pend   = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            gnt = req && ($urandom_range(0, 9) < 7);
            if (gnt) begin
                pend      = 1'b1;
                pend_cnt  = $urandom_range(0, 2);
                pend_addr = addr;
            end

            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) redir_pc = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            else                           redir_pc = 32'($urandom_range(0, 32'h0000_0FFF));
            if (redir) stream_pc = redir_pc & ~32'h3;

            p_stall    = stall;
            p_redir    = redir;
            p_req_wait = req && !gnt && !redir;
            p_addr     = addr;
            s_valid    = id_valid;
            s_pc       = id_pc;
            s_instr    = id_instr;
        end
    endtask

    initial begin
        rst      = 1'b0;
        stall    = 1'b0;
        redir    = 1'b0;
        redir_pc = '0;
        gnt      = 1'b0;
        rvalid   = 1'b0;
        rdata    = '0;
        deliveries = 0;
        reset_model();

        #1 rst = 1'b1;
        #2 check_reset_outputs("por");
        repeat (3) @(negedge clk);
        check_reset_outputs("por_clocked");
        rst = 1'b0;
        reset_model();

        run_cycles(3000);

        // Asynchronous reset while a fetch is outstanding
        for (int k = 0; k < 50 && !pend; k++) run_cycles(1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        gnt    = 1'b0;
        stall  = 1'b0;
        redir  = 1'b0;
        rvalid = 1'b1;
        rdata  = instr_of(32'h0000_0040);
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("stale_rvalid");
        @(negedge clk);
        rvalid = 1'b0;
        rst    = 1'b0;
        reset_model();

        run_cycles(1000);
        check("progress", {31'd0, (deliveries > 200)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
